// File: rtl/half_adder.sv
// rtl/half_adder.sv - multi-lane half adder with registered capture and a saturating carry-event counter
module half_adder #(
    parameter int WIDTH = 1,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    input  logic             clr_count,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] carry,
    output logic [WIDTH-1:0] sum_q,
    output logic [WIDTH-1:0] carry_q,
    output logic             out_valid,
    output logic [CNT_W-1:0] carry_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] carry_d;
    logic             valid_d;
    logic             valid_q;
    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    // Lanes are independent: no carry ripples between bit positions.
    always_comb begin
        sum   = a ^ b;
        carry = a & b;
    end

    always_comb begin
        sum_d   = sum_q;
        carry_d = carry_q;
        valid_d = in_valid;
        count_d = count_q;
        if (in_valid) begin
            sum_d   = a ^ b;
            carry_d = a & b;
        end
        // Clear wins over a coincident increment; the count sticks at all-ones.
        if (clr_count) begin
            count_d = '0;
        end else if (in_valid && (|(a & b)) && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q   <= '0;
            carry_q <= '0;
            valid_q <= 1'b0;
            count_q <= '0;
        end else begin
            sum_q   <= sum_d;
            carry_q <= carry_d;
            valid_q <= valid_d;
            count_q <= count_d;
        end
    end

    assign out_valid   = valid_q;
    assign carry_count = count_q;

endmodule

// File: tb/tb_half_adder.sv
// tb/tb_half_adder.sv - scoreboard bench for half_adder against a lane-arithmetic reference model
module tb_half_adder;

    localparam int W     = 4;
    localparam int CW    = 2;
    localparam int CMAX  = (1 << CW) - 1;

    typedef struct {
        logic [W-1:0] s;
        logic [W-1:0] c;
        int           cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          clr_count = 1'b0;
    logic [W-1:0]  a = '0, b = '0;
    logic [W-1:0]  sum, carry, sum_q, carry_q;
    logic          out_valid;
    logic [CW-1:0] carry_count;

    logic          a1 = 1'b0, b1 = 1'b0;
    logic          sum1, carry1, sum_q1, carry_q1, out_valid1;
    logic [7:0]    cnt1;
    logic [2:0]    a3 = '0, b3 = '0;
    logic [2:0]    sum3, carry3, sum_q3, carry_q3;
    logic          out_valid3;
    logic [7:0]    cnt3;

    int   n_cmp  = 0;
    int   n_fail = 0;
    int   cnt_m  = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    half_adder #(.WIDTH(W), .CNT_W(CW)) u_dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .in_valid(in_valid), .clr_count(clr_count),
        .sum(sum), .carry(carry), .sum_q(sum_q), .carry_q(carry_q),
        .out_valid(out_valid), .carry_count(carry_count)
    );

    half_adder #(.WIDTH(1), .CNT_W(8)) u_w1 (
        .clk(clk), .rst_n(rst_n), .a(a1), .b(b1), .in_valid(1'b0), .clr_count(1'b0),
        .sum(sum1), .carry(carry1), .sum_q(sum_q1), .carry_q(carry_q1),
        .out_valid(out_valid1), .carry_count(cnt1)
    );

    half_adder #(.WIDTH(3), .CNT_W(8)) u_w3 (
        .clk(clk), .rst_n(rst_n), .a(a3), .b(b3), .in_valid(1'b0), .clr_count(1'b0),
        .sum(sum3), .carry(carry3), .sum_q(sum_q3), .carry_q(carry_q3),
        .out_valid(out_valid3), .carry_count(cnt3)
    );

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: each lane adds two one-bit numbers; the two-bit result splits into sum and carry.
    function automatic void lane_add(input int n, input logic [31:0] x, input logic [31:0] y,
                                     output logic [31:0] s, output logic [31:0] c);
        s = 0;
        c = 0;
        for (int i = 0; i < n; i++) begin
            int t;
            t = int'(x[i]) + int'(y[i]);
            s[i] = (t % 2) != 0;
            c[i] = (t / 2) != 0;
        end
    endfunction

    task automatic check_comb(input string nm);
        logic [31:0] es, ec;
        lane_add(W, 32'(a), 32'(b), es, ec);
        cmp({nm, "_sum"}, 32'(sum), es);
        cmp({nm, "_carry"}, 32'(carry), ec);
    endtask

    // Drive one cycle's inputs just after the edge; predict what the next edge captures.
    task automatic drive(input logic [W-1:0] xa, input logic [W-1:0] xb,
                         input logic v, input logic clr);
        logic [31:0] es, ec;
        exp_t e;
        @(posedge clk);
        #2;
        a = xa;
        b = xb;
        in_valid = v;
        clr_count = clr;
        lane_add(W, 32'(xa), 32'(xb), es, ec);
        if (clr) cnt_m = 0;
        else if (v && ec != 0 && cnt_m < CMAX) cnt_m++;
        if (v) begin
            e.s = es[W-1:0];
            e.c = ec[W-1:0];
            e.cnt = cnt_m;
            sb.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sb.size() == 0) begin
                cmp("sb_unexpected_out_valid", 32'(out_valid), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                cmp("sb_sum_q", 32'(sum_q), 32'(e.s));
                cmp("sb_carry_q", 32'(carry_q), 32'(e.c));
                cmp("sb_carry_count", 32'(carry_count), 32'(e.cnt));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] es, ec;
        logic [W-1:0] hs, hc;

        // Reset state and combinational path during reset.
        a = 4'b1010;
        b = 4'b0110;
        #3;
        cmp("rst_sum_q", 32'(sum_q), 0);
        cmp("rst_carry_q", 32'(carry_q), 0);
        cmp("rst_out_valid", 32'(out_valid), 0);
        cmp("rst_count", 32'(carry_count), 0);
        cmp("rst_comb_sum", 32'(sum), 32'hC);
        cmp("rst_comb_carry", 32'(carry), 32'h2);

        // WIDTH=1 truth table, inputs held 20 time units each.
        for (int i = 0; i < 4; i++) begin
            a1 = i[1];
            b1 = i[0];
            #20;
            lane_add(1, 32'(a1), 32'(b1), es, ec);
            cmp("w1_sum", 32'(sum1), es);
            cmp("w1_carry", 32'(carry1), ec);
        end
        for (int i = 0; i < 64; i++) begin
            a3 = i[5:3];
            b3 = i[2:0];
            #1;
            lane_add(3, 32'(a3), 32'(b3), es, ec);
            cmp("w3_sum", 32'(sum3), es);
            cmp("w3_carry", 32'(carry3), ec);
        end
        for (int i = 0; i < 256; i++) begin
            a = i[7:4];
            b = i[3:0];
            #1;
            check_comb("w4_sweep");
        end

        // Valid held during reset must not be captured.
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        cmp("rst_ignores_valid", 32'(out_valid), 0);
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        drive(4'b1010, 4'b0110, 1'b1, 1'b0);
        #1;
        check_comb("directed");

        // Hold: capture a=b=1 in lane 0, then idle with changing inputs.
        drive(4'b0001, 4'b0001, 1'b1, 1'b0);
        hs = 4'b0000;
        hc = 4'b0001;
        for (int i = 0; i < 5; i++) begin
            drive(4'($urandom), 4'($urandom), 1'b0, 1'b0);
            #1;
            if (i > 0) begin
                cmp("hold_sum_q", 32'(sum_q), 32'(hs));
                cmp("hold_carry_q", 32'(carry_q), 32'(hc));
                cmp("hold_out_valid", 32'(out_valid), 0);
                cmp("hold_count", 32'(carry_count), 32'(cnt_m));
            end
        end

        // Clear alone, then saturate, then clear against an increment.
        drive('0, '0, 1'b0, 1'b1);
        drive('0, '0, 1'b0, 1'b0);
        #1;
        cmp("clr_count", 32'(carry_count), 0);
        for (int i = 0; i < 6; i++) drive(4'hF, 4'hF, 1'b1, 1'b0);
        drive(4'hF, 4'hF, 1'b1, 1'b1);
        drive('0, '0, 1'b0, 1'b0);

        // Randomized stream.
        for (int i = 0; i < 300; i++)
            drive(4'($urandom), 4'($urandom), 1'($urandom), ($urandom_range(0, 15) == 0));

        // Reset mid-stream, between edges.
        for (int i = 0; i < 4; i++) drive(4'($urandom), 4'hF, 1'b1, 1'b0);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        sb.delete();
        cnt_m = 0;
        #1;
        cmp("mid_rst_sum_q", 32'(sum_q), 0);
        cmp("mid_rst_carry_q", 32'(carry_q), 0);
        cmp("mid_rst_out_valid", 32'(out_valid), 0);
        cmp("mid_rst_count", 32'(carry_count), 0);
        a = 4'b0111;
        b = 4'b1101;
        #1;
        check_comb("mid_rst_comb");
        in_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b1;

        for (int i = 0; i < 40; i++)
            drive(4'($urandom), 4'($urandom), 1'($urandom), 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        drive('0, '0, 1'b0, 1'b0);
        #4;
        cmp("sb_drained", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
